ap_ctrl_launcher: RTL

- Synthesizable initiator for the HLS ap_ctrl_chain block-level handshake (ap_start/ap_ready/ap_done/ap_continue). It drives a kernel under test N times, overlapping launches up to a fixed depth.
- For each run it timestamps the launch and completion handshakes and reports total elapsed cycles plus min/max per-run latency.
- It sits between a host/testbench command port and the DUT kernel's control pins, and is used for on-chip DDR bandwidth/latency measurement runs.

---
 rtl/ap_ctrl_launcher_pkg.sv | 9 +
 rtl/ap_ctrl_launcher_ts.sv | 46 ++++
 rtl/ap_ctrl_launcher.sv | 104 ++++++++++
 3 files changed

// File: rtl/ap_ctrl_launcher_pkg.sv
// ap_ctrl_launcher_pkg: shared types and constants for the ap_ctrl_chain launcher
package ap_ctrl_launcher_pkg;
   localparam int CNT_W_DEF = 32;
   localparam int RUN_W_DEF = 16;
   typedef enum logic [1:0] {IDLE, LAUNCH, DRAIN, REPORT} state_t;
   typedef logic [CNT_W_DEF-1:0] cnt_t;
   typedef logic [RUN_W_DEF-1:0] run_t;
   localparam cnt_t LAT_INIT = '1;
endpackage

// File: rtl/ap_ctrl_launcher_ts.sv
// ts_fifo: launch-timestamp FIFO, one entry per outstanding kernel run
module ts_fifo #(
   parameter int DEPTH = 4,
   parameter int W = 32
) (
   input  logic         ap_clk,
   input  logic         ap_rst_n,
   input  logic         clear,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic         empty,
   output logic         full
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0] cnt;
   logic do_push, do_pop;
   assign empty = cnt == '0;
   assign full = cnt == (AW+1)'(DEPTH);
   assign do_push = push && (!full || pop);
   assign do_pop = pop && !empty;
   assign head = mem[rp];
   // storage is not reset; only the pointers define validity
   always_ff @(posedge ap_clk) begin
      if (do_push) mem[wp] <= din;
   end
   // pointer and occupancy bookkeeping, wiped on reset or command accept
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         wp <= '0;
         rp <= '0;
         cnt <= '0;
      end else if (clear) begin
         wp <= '0;
         rp <= '0;
         cnt <= '0;
      end else begin
         if (do_push) wp <= (wp == AW'(DEPTH-1)) ? '0 : wp + 1'b1;
         if (do_pop) rp <= (rp == AW'(DEPTH-1)) ? '0 : rp + 1'b1;
         cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/ap_ctrl_launcher.sv
// ap_ctrl_launcher: drives an ap_ctrl_chain kernel N times and measures per-run latency
module ap_ctrl_launcher
   import ap_ctrl_launcher_pkg::*;
#(
   parameter int RUN_W = RUN_W_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [RUN_W-1:0] cmd_runs,
   input  logic             hold_continue,
   output logic             ap_start,
   input  logic             ap_ready,
   input  logic             ap_done,
   output logic             ap_continue,
   output logic             busy,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [CNT_W-1:0] total_cycles,
   output logic [CNT_W-1:0] min_lat,
   output logic [CNT_W-1:0] max_lat,
   output logic             protocol_err
);
   localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
   state_t state, state_nx;
   logic [RUN_W-1:0] runs, launched, completed;
   logic [OW-1:0] outstanding;
   logic [CNT_W-1:0] now, lat, ts_head;
   logic accept, launch, comp, comp_ok, last_launch, last_comp;
   logic push, pop, fifo_empty, fifo_full;
   assign accept = cmd_valid && cmd_ready;
   assign launch = ap_start && ap_ready;
   assign comp = ap_done && ap_continue;
   assign comp_ok = comp && (outstanding != '0 || launch);
   assign last_launch = launch && (launched + 1'b1) == runs;
   assign last_comp = comp_ok && (completed + 1'b1) == runs;
   assign push = launch && !(comp_ok && fifo_empty);
   assign pop = comp_ok && !fifo_empty;
   assign lat = fifo_empty ? '0 : now - ts_head;
   ts_fifo #(.DEPTH(MAX_OUTSTANDING), .W(CNT_W)) u_ts (
      .ap_clk(ap_clk),
      .ap_rst_n(ap_rst_n),
      .clear(accept),
      .push(push),
      .pop(pop),
      .din(now),
      .head(ts_head),
      .empty(fifo_empty),
      .full(fifo_full)
   );
   // state register
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) state <= IDLE;
      else state <= state_nx;
   end
   // control outputs and next state, all from registered state and handshakes
   always_comb begin
      cmd_ready = state == IDLE;
      busy = state == LAUNCH || state == DRAIN;
      result_valid = state == REPORT;
      ap_start = state == LAUNCH && launched < runs && outstanding < OW'(MAX_OUTSTANDING) && !fifo_full;
      ap_continue = busy && !hold_continue;
      state_nx = (state == IDLE && cmd_valid) ? (cmd_runs == '0 ? REPORT : LAUNCH) :
                 last_comp ? REPORT :
                 last_launch ? DRAIN :
                 (state == REPORT && result_ready) ? IDLE : state;
   end
   // run bookkeeping, cycle clock and latency statistics
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         runs <= '0;
         launched <= '0;
         completed <= '0;
         outstanding <= '0;
         now <= '0;
         total_cycles <= '0;
         min_lat <= '1;
         max_lat <= '0;
         protocol_err <= 1'b0;
      end else if (accept) begin
         runs <= cmd_runs;
         launched <= '0;
         completed <= '0;
         outstanding <= '0;
         now <= '0;
         total_cycles <= '0;
         min_lat <= '1;
         max_lat <= '0;
         protocol_err <= 1'b0;
      end else if (busy) begin
         now <= (&now) ? now : now + 1'b1;
         launched <= launched + RUN_W'(launch);
         completed <= completed + RUN_W'(comp_ok);
         outstanding <= outstanding + OW'(launch) - OW'(comp_ok);
         if (comp && !comp_ok) protocol_err <= 1'b1;
         if (comp_ok && lat < min_lat) min_lat <= lat;
         if (comp_ok && lat > max_lat) max_lat <= lat;
         if (last_comp) total_cycles <= (&now) ? now : now + 1'b1;
      end
   end
endmodule
